// File: rtl/mux_accumulator_32b.sv
// Registered accumulate stage: sums COUNT accepted beats into one result word,
// then holds the result on a valid/ready output until the consumer takes it.
module mux_accumulator_32b #(
  parameter int WIDTH = 32,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [7:0]       beat_cnt
);

  // Handshake: a beat moves when in_valid && in_ready at the rising edge; a
  // result moves when out_valid && out_ready. in_ready depends on state only.
  typedef enum logic {ACC, DONE} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, in_data};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    case (state)
      ACC: begin
        if (flush) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          cnt_nxt = '0;
        end else if (in_valid) begin
          // First beat of a group overwrites, so the old result needs no clearing.
          if (cnt == 8'd0) begin
            acc_nxt = in_data;
            ovf_nxt = 1'b0;
          end else begin
            acc_nxt = sum[WIDTH-1:0];
            ovf_nxt = ovf | sum[WIDTH];
          end
          cnt_nxt = cnt + 8'd1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (flush) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else if (out_ready) begin
          state_nxt = ACC;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? acc : '0;
  assign out_ovf   = out_valid & ovf;
  assign beat_cnt  = cnt;

endmodule

// File: tb/tb_mux_accumulator_32b.sv
// Bench for mux_accumulator_32b with COUNT=4: random beats checked against a
// group-sum model computed with wide arithmetic.
module tb_mux_accumulator_32b;

  localparam int WIDTH = 32;
  localparam int COUNT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic [7:0]       beat_cnt;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf_q[$];
  logic [WIDTH-1:0] beats[$];

  mux_accumulator_32b #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a group result is the true sum truncated; overflow means the
  // true sum reached 2^WIDTH at any point, i.e. the final true sum did.
  function automatic void model_push(input logic [WIDTH-1:0] d);
    longint unsigned s;
    beats.push_back(d);
    if (beats.size() == COUNT) begin
      s = 0;
      foreach (beats[i]) s += longint'(beats[i]);
      exp_q.push_back(s[WIDTH-1:0]);
      exp_ovf_q.push_back((s >> WIDTH) != 0);
      beats.delete();
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
    end
    cyc();
    model_push(d);
    in_valid = 1'b0;
  endtask

  task automatic pop_result(output logic v, output logic [WIDTH-1:0] d, output logic o);
    int n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    v = out_valid;
    d = out_data;
    o = out_ovf;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic v, o;
    logic [WIDTH-1:0] d, e;
    logic eo;
    beat(32'd7);
    beat(32'd9);
    checks++;
    if (beat_cnt !== 8'd2) begin
      errors++;
      $display("FAIL reset_pre_cnt: got %0d required 2", beat_cnt);
    end
    #2 rst = 1'b1;
    #3;
    cyc();
    rst = 1'b0;
    beats.delete();
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 ||
        beat_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%0b data=%h ovf=%0b cnt=%0d ready=%0b required 0 0 0 0 1",
               out_valid, out_data, out_ovf, beat_cnt, in_ready);
    end
    for (int i = 1; i <= 4; i++) beat(WIDTH'(i));
    pop_result(v, d, o);
    e = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || o !== eo || d !== 32'd10) begin
      errors++;
      $display("FAIL reset_group: valid=%0b data=%h ovf=%0b required 1 %h %0b", v, d, o, e, eo);
    end
  endtask

  task automatic test_overflow();
    logic v, o;
    logic [WIDTH-1:0] d, e;
    logic eo;
    beat(32'hFFFF_FFFF); beat(32'h2); beat(32'h0); beat(32'h0);
    pop_result(v, d, o);
    e = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || o !== eo || o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_group: valid=%0b data=%h ovf=%0b required 1 %h %0b", v, d, o, e, eo);
    end
    for (int i = 0; i < 4; i++) beat(32'd1);
    pop_result(v, d, o);
    e = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || o !== eo) begin
      errors++;
      $display("FAIL ovf_clear: valid=%0b data=%h ovf=%0b required 1 %h %0b", v, d, o, e, eo);
    end
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) beat($urandom);
      pop_result(v, d, o);
      e = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      checks++;
      if (v !== 1'b1 || d !== e || o !== eo) begin
        errors++;
        $display("FAIL rand_group%0d: valid=%0b data=%h ovf=%0b required 1 %h %0b", g, v, d, o, e, eo);
      end
    end
  endtask

  task automatic test_backpressure();
    logic v, o;
    logic [WIDTH-1:0] d, e;
    logic eo;
    for (int i = 0; i < 4; i++) beat($urandom);
    e = exp_q[0];
    eo = exp_ovf_q[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_ovf !== eo ||
          in_ready !== 1'b0 || beat_cnt !== 8'd4) begin
        errors++;
        $display("FAIL hold_cyc%0d: valid=%0b data=%h ovf=%0b ready=%0b cnt=%0d required 1 %h %0b 0 4",
                 i, out_valid, out_data, out_ovf, in_ready, beat_cnt, e, eo);
      end
    end
    in_valid = 1'b0;
    pop_result(v, d, o);
    e = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || o !== eo) begin
      errors++;
      $display("FAIL hold_release: valid=%0b data=%h ovf=%0b required 1 %h %0b", v, d, o, e, eo);
    end
  endtask

  task automatic test_gaps();
    logic v, o;
    logic [WIDTH-1:0] d, e;
    logic eo;
    int accepted = 0;
    checks++;
    if (beat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL gap_start: cnt=%0d required 0", beat_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'd5;
      cyc();
      if (i % 2 == 0) begin
        accepted++;
        model_push(32'd5);
      end
      checks++;
      if (beat_cnt !== 8'(accepted) || out_valid !== (accepted == COUNT)) begin
        errors++;
        $display("FAIL gap_cyc%0d: cnt=%0d valid=%0b required %0d %0b",
                 i, beat_cnt, out_valid, accepted, accepted == COUNT);
      end
    end
    in_valid = 1'b0;
    pop_result(v, d, o);
    e = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || o !== eo || d !== 32'd20) begin
      errors++;
      $display("FAIL gap_group: valid=%0b data=%h ovf=%0b required 1 %h %0b", v, d, o, e, eo);
    end
  endtask

  task automatic test_flush();
    logic v, o;
    logic [WIDTH-1:0] d, e;
    logic eo;
    for (int i = 0; i < 3; i++) beat($urandom_range(100, 1));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd9;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    beats.delete();
    checks++;
    if (beat_cnt !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_acc: cnt=%0d valid=%0b ready=%0b required 0 0 1", beat_cnt, out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) beat(32'd2);
    pop_result(v, d, o);
    e = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== e || o !== eo || d !== 32'd8) begin
      errors++;
      $display("FAIL flush_group: valid=%0b data=%h ovf=%0b required 1 %h %0b", v, d, o, e, eo);
    end
    for (int i = 0; i < 4; i++) beat($urandom);
    flush     = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush     = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_ovf_q.pop_back());
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || beat_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: valid=%0b data=%h cnt=%0d ready=%0b required 0 0 0 1",
               out_valid, out_data, beat_cnt, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] e;
    logic eo;
    int results = 0;
    int low = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = $urandom;
      checks++;
      if (in_ready !== (i % 5 != 4) || out_valid !== (i % 5 == 4)) begin
        errors++;
        $display("FAIL b2b_cyc%0d: ready=%0b valid=%0b required %0b %0b",
                 i, in_ready, out_valid, i % 5 != 4, i % 5 == 4);
      end
      if (i % 5 == 4) begin
        low++;
        e = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        checks++;
        if (out_data !== e || out_ovf !== eo) begin
          errors++;
          $display("FAIL b2b_result%0d: data=%h ovf=%0b required %h %0b", results, out_data, out_ovf, e, eo);
        end
        results++;
      end else begin
        model_push(in_data);
      end
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (results != 3 || low != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: results=%0d pending=%0d required 3 0", results, exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #23;
    rst = 1'b0;
    cyc();
    test_reset();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
